// File: rtl/w5300_pkg.sv
// Shared definitions for the W5300 host bus controller: FSM encoding and
// the helper that turns a nanosecond timing figure into whole clock cycles.
package w5300_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_RECOVER
    } bus_state_t;

    // ceil(t_ns * clk_mhz / 1000), never less than one cycle
    function automatic int ceil_cyc(input int t_ns, input int clk_mhz);
        int c;
        c = (t_ns * clk_mhz + 999) / 1000;
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/w5300_int_sync.sv
// Two-flop synchronizer for the W5300 int_n line with a falling-edge detector
// producing a single-cycle irq pulse (used when W5300_BUS_INT_SYNC_EN is set).
module w5300_int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic int_n,
    output logic irq
);

    // sync[1:0] is the synchronizer, sync[2] remembers the previous sample
    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
            irq  <= 1'b0;
        end else begin
            sync <= {sync[1:0], int_n};
            irq  <= sync[2] & ~sync[1];
        end
    end

endmodule

// File: rtl/w5300_bus_ctrl.sv
// W5300 parallel host-bus controller: timed SETUP/ACCESS/HOLD/RECOVER cycles
// with fixed-address bursts. Define W5300_BUS_INT_SYNC_EN to synchronize int_n.
module w5300_bus_ctrl
    import w5300_pkg::*;
#(
    parameter int CLK_FREQ    = 100,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int T_ACC_NS    = 70,
    parameter int T_RCV_NS    = 30,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req,
    input  logic                   wr,
    input  logic [ADDR_WIDTH-1:0]  addr_in,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   ack,
    input  logic [DATA_WIDTH-1:0]  wdata,
    output logic                   wready,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic                   rvalid,
    output logic                   done,
    inout  tri   [DATA_WIDTH-1:0]  data,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic                   cs_n,
    output logic                   rd_n,
    output logic                   we_n,
    output logic                   rw_n,
    input  logic                   int_n,
    output logic                   irq
);

    localparam int ACC_CYC = ceil_cyc(T_ACC_NS, CLK_FREQ);
    localparam int RCV_CYC = ceil_cyc(T_RCV_NS, CLK_FREQ);
    localparam int MAX_CYC = (ACC_CYC > RCV_CYC) ? ACC_CYC : RCV_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC_CYC - 1);
    localparam logic [CNT_W-1:0] RCV_LAST = CNT_W'(RCV_CYC - 1);

    bus_state_t             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [BURST_WIDTH-1:0] remain, remain_nxt;
    logic                   wr_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   data_oe;

    logic acc_last, rcv_last, start, word_start, wr_eff, in_cyc_nxt, rd_last;

    assign acc_last   = (cnt == ACC_LAST);
    assign rcv_last   = (cnt == RCV_LAST);
    assign start      = (state == ST_IDLE) && req;
    assign word_start = (state_nxt == ST_SETUP) && (state != ST_SETUP);
    // direction of the word about to start: the request input when accepting
    assign wr_eff     = (state == ST_IDLE) ? wr : wr_q;
    assign in_cyc_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS) ||
                        (state_nxt == ST_HOLD);
    assign rd_last    = (state == ST_ACCESS) && acc_last && !wr_q;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        remain_nxt = remain;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt  = ST_SETUP;
                    remain_nxt = burst_len;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
                cnt_nxt   = '0;
            end
            ST_ACCESS: begin
                if (acc_last) state_nxt = ST_HOLD;
                else          cnt_nxt   = cnt + 1'b1;
            end
            ST_HOLD: begin
                state_nxt = ST_RECOVER;
                cnt_nxt   = '0;
            end
            ST_RECOVER: begin
                if (!rcv_last) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (remain != '0) begin
                    state_nxt  = ST_SETUP;
                    remain_nxt = remain - 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus strobes are registered from the next state so they are glitch-free
    // and line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            remain  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            we_n    <= 1'b1;
            rw_n    <= 1'b1;
            data_oe <= 1'b0;
            ack     <= 1'b0;
            wready  <= 1'b0;
            rvalid  <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            remain  <= remain_nxt;
            if (start) begin
                wr_q   <= wr;
                addr_q <= addr_in;
            end
            cs_n    <= !in_cyc_nxt;
            rd_n    <= !((state_nxt == ST_ACCESS) && !wr_eff);
            we_n    <= !((state_nxt == ST_ACCESS) && wr_eff);
            rw_n    <= in_cyc_nxt ? !wr_eff : 1'b1;
            data_oe <= in_cyc_nxt && wr_eff;
            ack     <= start;
            wready  <= word_start && wr_eff;
            rvalid  <= rd_last;
            done    <= (state == ST_RECOVER) && (state_nxt == ST_IDLE);
            if (rd_last) rdata <= data;
        end
    end

    // Write-data holding register is pure datapath; no reset needed.
    always_ff @(posedge clk) begin
        if (word_start && wr_eff) wdata_q <= wdata;
    end

    assign addr = addr_q;
    assign data = data_oe ? wdata_q : {DATA_WIDTH{1'bz}};

`ifdef W5300_BUS_INT_SYNC_EN
    w5300_int_sync u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .int_n (int_n),
        .irq   (irq)
    );
`else
    assign irq = rst_n & ~int_n;
`endif

endmodule
